// File: rtl/gun_shot_ctrl.sv
// Light-gun shot sequencer: black frame, target frame(s) with photodiode sampling, hit/miss, ammo, cooldown.
// Optional: define GUN_BLACK_CHECK_EN to score light seen during the black frame as a miss.
module gun_shot_ctrl #(
  parameter int AMMO_MAX        = 3,
  parameter int AMMO_W          = 2,
  parameter int TARGET_FRAMES   = 1,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig_tick,
  input  logic              reload,
  input  logic              frame_tick,
  input  logic              light_in,
  output logic              flash_black,
  output logic              flash_target,
  output logic              shot_tick,
  output logic              dry_tick,
  output logic              hit_tick,
  output logic              miss_tick,
  output logic [AMMO_W-1:0] ammo,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_BLACK,
    S_TARGET,
    S_RESULT,
    S_COOLDOWN
  } state_t;

  localparam logic [AMMO_W-1:0] AMMO_LOAD = AMMO_W'(AMMO_MAX);
  localparam logic [AMMO_W-1:0] AMMO_ONE  = AMMO_W'(1);
  localparam logic [7:0]        TGT_LOAD  = 8'(TARGET_FRAMES - 1);
  localparam logic [7:0]        COOL_LOAD = 8'(COOLDOWN_FRAMES);

  state_t            state_reg, state_next;
  logic [7:0]        fcnt_reg, fcnt_next;
  logic [AMMO_W-1:0] ammo_reg, ammo_next;
  logic              hit_reg, hit_next;
  logic              cheat_reg, cheat_next;
  logic              shot_reg, shot_next;
  logic              dry_reg, dry_next;
  logic [1:0]        light_sync_reg;
  logic              light_s;
  logic              black_light;

  // Photodiode is asynchronous; two flops before any decision uses it.
  always_ff @(posedge clk) begin
    if (reset) begin
      light_sync_reg <= 2'b00;
    end else begin
      light_sync_reg <= {light_sync_reg[0], light_in};
    end
  end

  assign light_s = light_sync_reg[1];

`ifdef GUN_BLACK_CHECK_EN
  assign black_light = light_s;
`else
  assign black_light = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      fcnt_reg  <= 8'd0;
      ammo_reg  <= AMMO_LOAD;
      hit_reg   <= 1'b0;
      cheat_reg <= 1'b0;
      shot_reg  <= 1'b0;
      dry_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
      ammo_reg  <= ammo_next;
      hit_reg   <= hit_next;
      cheat_reg <= cheat_next;
      shot_reg  <= shot_next;
      dry_reg   <= dry_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fcnt_next  = fcnt_reg;
    ammo_next  = ammo_reg;
    hit_next   = hit_reg;
    cheat_next = cheat_reg;
    shot_next  = 1'b0;
    dry_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // Reload wins over a coincident trigger.
        if (reload) begin
          ammo_next = AMMO_LOAD;
        end else if (trig_tick) begin
          if (ammo_reg != '0) begin
            state_next = S_ARM;
            ammo_next  = ammo_reg - AMMO_ONE;
            hit_next   = 1'b0;
            cheat_next = 1'b0;
            shot_next  = 1'b1;
          end else begin
            dry_next = 1'b1;
          end
        end
      end

      S_ARM: begin
        if (frame_tick) begin
          state_next = S_BLACK;
        end
      end

      S_BLACK: begin
        if (black_light) begin
          cheat_next = 1'b1;
        end
        if (frame_tick) begin
          state_next = S_TARGET;
          fcnt_next  = TGT_LOAD;
        end
      end

      S_TARGET: begin
        if (light_s) begin
          hit_next = 1'b1;
        end
        if (frame_tick) begin
          if (fcnt_reg == 8'd0) begin
            state_next = S_RESULT;
          end else begin
            fcnt_next = fcnt_reg - 8'd1;
          end
        end
      end

      S_RESULT: begin
        if (COOLDOWN_FRAMES == 0) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_COOLDOWN;
          fcnt_next  = COOL_LOAD;
        end
      end

      S_COOLDOWN: begin
        if (frame_tick) begin
          if (fcnt_reg == 8'd1) begin
            state_next = S_IDLE;
          end else begin
            fcnt_next = fcnt_reg - 8'd1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign flash_black  = (state_reg == S_BLACK);
  assign flash_target = (state_reg == S_TARGET);
  assign busy         = (state_reg != S_IDLE);
  assign hit_tick     = (state_reg == S_RESULT) & hit_reg & ~cheat_reg;
  assign miss_tick    = (state_reg == S_RESULT) & (~hit_reg | cheat_reg);
  assign shot_tick    = shot_reg;
  assign dry_tick     = dry_reg;
  assign ammo         = ammo_reg;

endmodule

// File: tb/tb_gun_shot_ctrl.sv
// Self-checking bench for gun_shot_ctrl: directed vector table, hand sequences, and a
// randomized run scored against a frame-schedule reference model.
module tb_gun_shot_ctrl;

  localparam int AMMO_MAX = 3;
  localparam int TGT      = 1;
  localparam int COOL     = 15;
  localparam int N        = 4000;
`ifdef GUN_BLACK_CHECK_EN
  localparam bit CHEAT_EN = 1'b1;
`else
  localparam bit CHEAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic trig_tick = 1'b0, reload = 1'b0, frame_tick = 1'b0, light_in = 1'b0;
  logic flash_black, flash_target, shot_tick, dry_tick, hit_tick, miss_tick, busy;
  logic [1:0] ammo;

  int checks = 0;
  int errors = 0;
  int n_shot, n_dry, n_hit, n_miss, n_black, n_target;

  gun_shot_ctrl dut (
    .clk(clk), .reset(reset), .trig_tick(trig_tick), .reload(reload),
    .frame_tick(frame_tick), .light_in(light_in),
    .flash_black(flash_black), .flash_target(flash_target), .shot_tick(shot_tick),
    .dry_tick(dry_tick), .hit_tick(hit_tick), .miss_tick(miss_tick),
    .ammo(ammo), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Flag order: busy, flash_black, flash_target, shot, dry, hit, miss.
  function automatic logic [6:0] outs();
    return {busy, flash_black, flash_target, shot_tick, dry_tick, hit_tick, miss_tick};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clear_cnt();
    n_shot = 0; n_dry = 0; n_hit = 0; n_miss = 0; n_black = 0; n_target = 0;
  endtask

  // Drive one cycle of inputs, then observe the outputs that result.
  task automatic cyc(input logic t, input logic r, input logic f, input logic l);
    trig_tick = t; reload = r; frame_tick = f; light_in = l;
    @(negedge clk);
    if (shot_tick)    n_shot++;
    if (dry_tick)     n_dry++;
    if (hit_tick)     n_hit++;
    if (miss_tick)    n_miss++;
    if (flash_black)  n_black++;
    if (flash_target) n_target++;
  endtask

  // One 4-cycle frame, frame_tick on its last cycle.
  task automatic tick(input logic l, input logic trig_first);
    for (int i = 0; i < 3; i++) cyc((i == 0) && trig_first, 1'b0, 1'b0, l);
    cyc(1'b0, 1'b0, 1'b1, l);
  endtask

  task automatic run_shot(input logic lb, input logic lt, input logic trig_black, output int cool);
    clear_cnt();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(lb, trig_black);
    tick(lt, 1'b0);
    cool = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1'b0, 1'b0);
      if (!busy) begin
        cool = k;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; trig_tick = 0; reload = 0; frame_tick = 0; light_in = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic       trig;
    logic       rel;
    logic       ft;
    logic       light;
    logic [6:0] flags;
    logic [1:0] ammo;
  } vec_t;

  vec_t vt[11];

  // Random stimulus and reference expectations
  bit r_trig[N], r_rel[N], r_ft[N], r_light[N];
  bit e_busy[N], e_fb[N], e_ftg[N], e_shot[N], e_dry[N], e_hit[N], e_miss[N];
  int e_ammo[N];

  function automatic int next_ft(input int x);
    for (int k = x; k < N; k++) if (r_ft[k]) return k;
    return N + 10;
  endfunction

  // Each accepted shot is laid out on the known frame_tick schedule: ARM ends on the first
  // tick after the trigger, BLACK lasts one frame, TARGET TGT frames, RESULT one cycle,
  // COOLDOWN until the COOL-th tick after RESULT.
  task automatic build_model();
    int  idle_from, cur, f1, f2, fend, r, k;
    bit  hit, cheat;
    idle_from = 0;
    cur = AMMO_MAX;
    for (int c = 0; c < N; c++) begin
      e_busy[c] = 0; e_fb[c] = 0; e_ftg[c] = 0; e_shot[c] = 0;
      e_dry[c] = 0; e_hit[c] = 0; e_miss[c] = 0;
    end
    for (int c = 0; c < N; c++) begin
      e_ammo[c] = cur;
      if (c >= idle_from) begin
        if (r_rel[c]) begin
          cur = AMMO_MAX;
        end else if (r_trig[c]) begin
          if (cur == 0) begin
            if (c + 1 < N) e_dry[c+1] = 1;
          end else begin
            cur--;
            if (c + 1 < N) e_shot[c+1] = 1;
            f1 = next_ft(c + 1);
            f2 = next_ft(f1 + 1);
            fend = f2;
            for (int i = 0; i < TGT; i++) fend = next_ft(fend + 1);
            r = fend + 1;
            k = r;
            for (int i = 0; i < COOL; i++) k = next_ft(k + 1);
            idle_from = (COOL > 0) ? k + 1 : r + 1;
            hit = 0;
            cheat = 0;
            for (int j = f1 + 1; j <= f2 && j < N; j++)
              if (j >= 2 && r_light[j-2] && CHEAT_EN) cheat = 1;
            for (int j = f2 + 1; j <= fend && j < N; j++)
              if (j >= 2 && r_light[j-2]) hit = 1;
            for (int j = c + 1; j < idle_from && j < N; j++) e_busy[j] = 1;
            for (int j = f1 + 1; j <= f2 && j < N; j++) e_fb[j] = 1;
            for (int j = f2 + 1; j <= fend && j < N; j++) e_ftg[j] = 1;
            if (r < N) begin
              e_hit[r]  = hit & ~cheat;
              e_miss[r] = ~hit | cheat;
            end
          end
        end
      end
    end
  endtask

  initial begin
    int cool, gap, nprint;
    bit lvl;
    logic [8:0] got, exp;

    // trig, reload, frame, light, {busy,fb,ftg,shot,dry,hit,miss}, ammo
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 2'd3};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b1001000, 2'd2};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b1000000, 2'd2};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b1100000, 2'd2};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b1100000, 2'd2};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b1010000, 2'd2};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b1010000, 2'd2};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b1010000, 2'd2};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b1010000, 2'd2};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b1000010, 2'd2};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b1000000, 2'd2};

    do_reset();
    chk("reset_flags", 32'(outs()), 32'd0);
    chk("reset_ammo", 32'(ammo), 32'd3);

    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].trig, vt[i].rel, vt[i].ft, vt[i].light);
      got = {outs(), ammo};
      exp = {vt[i].flags, vt[i].ammo};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d got=%b exp=%b", i, got, exp);
      end
    end

    // Trigger during COOLDOWN is ignored; cooldown lasts 15 frame ticks.
    clear_cnt();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("cool_trig_shot", 32'(n_shot), 32'd0);
    chk("cool_trig_ammo", 32'(ammo), 32'd2);
    cool = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1'b0, 1'b0);
      if (!busy) begin
        cool = k;
        break;
      end
    end
    chk("cool_ticks", 32'(cool), 32'd15);

    clear_cnt();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("reload_ammo", 32'(ammo), 32'd3);

    // Light only during TARGET -> hit.
    run_shot(1'b0, 1'b1, 1'b0, cool);
    chk("a_shot", 32'(n_shot), 32'd1);
    chk("a_black_cycles", 32'(n_black), 32'd4);
    chk("a_target_cycles", 32'(n_target), 32'd4);
    chk("a_hit", 32'(n_hit), 32'd1);
    chk("a_miss", 32'(n_miss), 32'd0);
    chk("a_cool", 32'(cool), 32'd15);
    chk("a_ammo", 32'(ammo), 32'd2);

    // Light during BLACK and TARGET -> miss only when black checking is built in.
    run_shot(1'b1, 1'b1, 1'b0, cool);
    chk("b_hit", 32'(n_hit), CHEAT_EN ? 32'd0 : 32'd1);
    chk("b_miss", 32'(n_miss), CHEAT_EN ? 32'd1 : 32'd0);
    chk("b_ammo", 32'(ammo), 32'd1);

    // Dark shot with a trigger pulled during BLACK.
    run_shot(1'b0, 1'b0, 1'b1, cool);
    chk("c_shot", 32'(n_shot), 32'd1);
    chk("c_miss", 32'(n_miss), 32'd1);
    chk("c_hit", 32'(n_hit), 32'd0);
    chk("c_ammo", 32'(ammo), 32'd0);

    clear_cnt();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("dry_tick", 32'(n_dry), 32'd1);
    chk("dry_busy", 32'(busy), 32'd0);
    chk("dry_shot", 32'(n_shot), 32'd0);

    clear_cnt();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rel_trig_ammo", 32'(ammo), 32'd3);
    chk("rel_trig_shot", 32'(n_shot), 32'd0);
    chk("rel_trig_dry", 32'(n_dry), 32'd0);

    // Reset while in TARGET with light present: sequence aborts silently.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_target", 32'(flash_target), 32'd1);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    chk("rst_flags", 32'(outs()), 32'd0);
    chk("rst_ammo", 32'(ammo), 32'd3);
    clear_cnt();
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    chk("rst_no_result", 32'(n_hit + n_miss), 32'd0);

    // Randomized run against the reference model.
    gap = 5;
    lvl = 0;
    for (int c = 0; c < N; c++) begin
      r_ft[c] = (gap == 0);
      if (gap == 0) gap = $urandom_range(3, 9);
      else gap--;
      r_trig[c] = ($urandom_range(0, 11) == 0);
      r_rel[c]  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 5) == 0) lvl = ~lvl;
      r_light[c] = lvl;
    end
    build_model();
    do_reset();
    nprint = 0;
    for (int c = 0; c < N; c++) begin
      got = {outs(), ammo};
      exp = {e_busy[c], e_fb[c], e_ftg[c], e_shot[c], e_dry[c], e_hit[c], e_miss[c],
             2'(e_ammo[c])};
      checks++;
      if (got !== exp) begin
        errors++;
        if (nprint < 10) $display("FAIL rand cyc %0d got=%b exp=%b", c, got, exp);
        nprint++;
      end
      trig_tick = r_trig[c]; reload = r_rel[c]; frame_tick = r_ft[c]; light_in = r_light[c];
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
